// File: rtl/supersonic_ranger.sv
// supersonic_ranger -- HC-SR04 ranging responder.
// On a trigger request (accepted only in IDLE with the synced echo low) it
// emits a TRIG_CYCLES-wide sensor trigger pulse, then waits for the echo to
// rise and times the echo-high period in units of CYC_PER_UNIT cycles.
// Every request ends in exactly one valid (distance updated) or fail pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   trigger           measurement request level
//   triggerSuc        1-cycle pulse, sensor trigger pulse finished
//   valid / fail      1-cycle result pulses (mutually exclusive)
//   distance          last measured distance, held between valids
//   busy              high whenever the FSM is not IDLE
//   sr_trig / sr_echo sensor TRIG output / asynchronous ECHO input
module supersonic_ranger #(
    parameter int DisLen       = 16,
    parameter int TRIG_CYCLES  = 500,
    parameter int CYC_PER_UNIT = 290,
    parameter int WAIT_TIMEOUT = 50000,
    parameter int ECHO_TIMEOUT = 1500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    output logic            triggerSuc,
    output logic            valid,
    output logic            fail,
    output logic [DisLen:0] distance,
    output logic            busy,
    output logic            sr_trig,
    input  logic            sr_echo
);
    localparam int TW = (TRIG_CYCLES  > 1) ? $clog2(TRIG_CYCLES)  : 1;
    localparam int PW = (CYC_PER_UNIT > 1) ? $clog2(CYC_PER_UNIT) : 1;
    localparam int WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam int EW = (ECHO_TIMEOUT > 1) ? $clog2(ECHO_TIMEOUT) : 1;

    // Terminal counts: counters run 0..N-1, so the Nth cycle is the last one.
    localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYC_PER_UNIT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_TIMEOUT - 1);
    localparam logic [EW-1:0] ECHO_LAST  = EW'(ECHO_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, TRIG, WAIT_RISE, COUNT} state_t;

    state_t          state;
    logic            echo_ff1, echo_s;
    logic [TW-1:0]   trig_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [EW-1:0]   echo_cnt;
    logic [PW-1:0]   presc;
    logic [DisLen:0] dist_cnt;
    logic [DisLen:0] dist_nxt;

    // Unit counter after this cycle's prescaler tick, saturating at all-ones.
    always_comb begin
        dist_nxt = dist_cnt;
        if (presc == PRESC_LAST && dist_cnt != '1)
            dist_nxt = dist_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            echo_ff1   <= 1'b0;
            echo_s     <= 1'b0;
            trig_cnt   <= '0;
            wait_cnt   <= '0;
            echo_cnt   <= '0;
            presc      <= '0;
            dist_cnt   <= '0;
            distance   <= '0;
            triggerSuc <= 1'b0;
            valid      <= 1'b0;
            fail       <= 1'b0;
            busy       <= 1'b0;
            sr_trig    <= 1'b0;
        end else begin
            echo_ff1   <= sr_echo;
            echo_s     <= echo_ff1;
            triggerSuc <= 1'b0;
            valid      <= 1'b0;
            fail       <= 1'b0;
            case (state)
                IDLE: begin
                    // A still-high echo from a previous shot blocks new requests.
                    if (trigger && !echo_s) begin
                        state    <= TRIG;
                        sr_trig  <= 1'b1;
                        busy     <= 1'b1;
                        trig_cnt <= '0;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        sr_trig    <= 1'b0;
                        triggerSuc <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= WAIT_RISE;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (echo_s) begin
                        presc    <= '0;
                        dist_cnt <= '0;
                        echo_cnt <= '0;
                        state    <= COUNT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                COUNT: begin
                    // Every COUNT cycle, including the one that sees the fall,
                    // is one echo-high cycle: rise and fall detection share the
                    // same synchroniser latency, so the lag cancels out.
                    presc    <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                    dist_cnt <= dist_nxt;
                    if (!echo_s) begin
                        distance <= dist_nxt;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (echo_cnt == ECHO_LAST) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        echo_cnt <= echo_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    sr_trig <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_supersonic_ranger.sv
module tb_supersonic_ranger;
    localparam int DL   = 4;     // 5-bit distance so saturation is reachable
    localparam int TRIG = 4;
    localparam int CPU  = 3;
    localparam int WT   = 20;
    localparam int ET   = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic        triggerSuc, valid, fail, busy, sr_trig;
    logic [DL:0] distance;
    logic        sr_echo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [DL:0] exp_dist = '0;

    supersonic_ranger #(
        .DisLen(DL), .TRIG_CYCLES(TRIG), .CYC_PER_UNIT(CPU),
        .WAIT_TIMEOUT(WT), .ECHO_TIMEOUT(ET)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .triggerSuc(triggerSuc),
        .valid(valid), .fail(fail), .distance(distance), .busy(busy),
        .sr_trig(sr_trig), .sr_echo(sr_echo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full request. Raw echo is high during cycles j..j+L-1 counted from
    // the triggerSuc cycle (L=0: never). Expected result from the timing rules:
    // synced echo lags raw by 2 cycles on both edges; it must rise before
    // WT cycles after triggerSuc; echo-high of L cycles gives floor(L/CPU)
    // units, valid one cycle after the synced fall; more than ET high cycles
    // gives fail one cycle after the ET-th.
    task automatic run_meas(input string name, input int j, input int L, input bit poke);
        int hi_cnt, suc_at, k, exp_n, n_end, got_n, nv, nf;
        bit exp_valid, dist_ok, overlap;
        logic [DL:0] new_dist, cur;
        hi_cnt = 0; suc_at = -1;
        trigger = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            trigger = 1'b0;
            if (triggerSuc) begin suc_at = i; break; end
            if (sr_trig && busy) hi_cnt++;
        end
        n_checks++;
        if (suc_at !== TRIG + 1 || hi_cnt !== TRIG) begin
            n_fail++;
            $display("FAIL %s trig_pulse: triggerSuc at %0d, sr_trig high %0d cycles; want %0d and %0d",
                     name, suc_at, hi_cnt, TRIG + 1, TRIG);
        end

        k = j + 2;
        new_dist = exp_dist;
        if (L > 0 && k < WT) begin
            if (L <= ET) begin
                exp_valid = 1'b1;
                exp_n     = k + L + 1;
                new_dist  = ((L / CPU) > (2**(DL+1) - 1)) ? '1 : (DL+1)'(L / CPU);
            end else begin
                exp_valid = 1'b0;
                exp_n     = k + ET + 1;
            end
        end else begin
            exp_valid = 1'b0;
            exp_n     = WT;
        end
        n_end = ((exp_n > j + L) ? exp_n : j + L) + 3;

        got_n = -1; nv = 0; nf = 0; dist_ok = 1'b1; overlap = 1'b0;
        for (int n = 0; n <= n_end; n++) begin
            if (n > 0) step();
            sr_echo = (n >= j && n < j + L);
            trigger = poke && (n == k + 5);
            cur = (exp_valid && n >= exp_n) ? new_dist : exp_dist;
            if (distance !== cur) dist_ok = 1'b0;
            if (valid && fail) overlap = 1'b1;
            if (valid) begin nv++; got_n = n; end
            if (fail)  begin nf++; got_n = n; end
        end
        sr_echo = 1'b0; trigger = 1'b0;

        n_checks++;
        if (nv !== (exp_valid ? 1 : 0) || nf !== (exp_valid ? 0 : 1) || got_n !== exp_n) begin
            n_fail++;
            $display("FAIL %s result: valid x%0d fail x%0d at %0d; want %s once at %0d",
                     name, nv, nf, got_n, exp_valid ? "valid" : "fail", exp_n);
        end
        n_checks++;
        if (!dist_ok || distance !== new_dist) begin
            n_fail++;
            $display("FAIL %s distance: got %0d, want %0d (held %0d before result)",
                     name, distance, new_dist, exp_dist);
        end
        n_checks++;
        if (overlap || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_state: overlap=%0b busy=%0b; want 0 and 0", name, overlap, busy);
        end
        exp_dist = new_dist;
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger = 1'b0; sr_echo = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({sr_trig, triggerSuc, valid, fail, busy} !== 5'b0 || distance !== '0) begin
            n_fail++;
            $display("FAIL reset: trig/suc/valid/fail/busy=%b distance=%0d; want 00000 and 0",
                     {sr_trig, triggerSuc, valid, fail, busy}, distance);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_meas("basic_30", 3, 30, 1'b0);
        run_meas("basic_7", 0, 7, 1'b0);
    endtask

    task automatic test_no_echo();
        run_meas("no_echo", 0, 0, 1'b0);
    endtask

    task automatic test_wait_boundary();
        run_meas("wait_last_ok", 17, 12, 1'b0);
        run_meas("wait_too_late", 18, 12, 1'b0);
    endtask

    task automatic test_echo_timeout();
        run_meas("echo_150", 2, 150, 1'b0);
        run_meas("echo_101", 1, 101, 1'b0);
        run_meas("echo_99_sat", 1, 99, 1'b0);
        run_meas("echo_93_max", 1, 93, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_meas("retrigger_in_count", 2, 40, 1'b1);
        run_meas("after_retrigger", 0, 9, 1'b0);
    endtask

    // Request while the synced echo is still high must wait for its fall.
    task automatic test_echo_stuck();
        bit idle_ok, seen;
        int b2, b3;
        sr_echo = 1'b1;
        repeat (3) step();
        trigger = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy || sr_trig) idle_ok = 1'b0;
        end
        sr_echo = 1'b0;
        step();
        step(); b2 = busy;
        step(); b3 = busy;
        trigger = 1'b0;
        n_checks++;
        if (!idle_ok || b2 !== 0 || b3 !== 1) begin
            n_fail++;
            $display("FAIL echo_stuck_ignore: idle_while_high=%0b busy@+2=%0d busy@+3=%0d; want 1,0,1",
                     idle_ok, b2, b3);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (fail) seen = 1'b1;
        end
        repeat (2) step();
        n_checks++;
        if (!seen || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL echo_stuck_finish: fail_seen=%0b busy=%0b; want 1 and 0", seen, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (sr_trig !== 1'b0 || busy !== 1'b0 || distance !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: sr_trig=%0b busy=%0b distance=%0d; want 0,0,0",
                     sr_trig, busy, distance);
        end
        exp_dist = '0;
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (triggerSuc || valid || fail || sr_trig) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: pulses seen after reset; want none");
        end
    endtask

    task automatic test_random();
        int j, L;
        for (int t = 0; t < 12; t++) begin
            j = $urandom_range(0, 22);
            L = $urandom_range(0, 125);
            if (L == ET) L = ET - 1;
            run_meas($sformatf("rand%0d_j%0d_L%0d", t, j, L), j, L, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_no_echo();
        test_wait_boundary();
        test_echo_timeout();
        test_back_to_back();
        test_echo_stuck();
        run_meas("before_reset_mid", 0, 15, 1'b0);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
